// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD frame path.
//  - ST7789 command opcodes used to re-arm the write window each frame
//  - number of bytes in the window command sequence
//  - frame scheduler state encoding
package lcd_pkg;

  localparam logic [7:0] CASET = 8'h2A;  // column address set
  localparam logic [7:0] RASET = 8'h2B;  // row address set
  localparam logic [7:0] RAMWR = 8'h2C;  // memory write, pixel data follows

  // CASET + 4 args, RASET + 4 args, RAMWR
  localparam int unsigned CMD_BYTES = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WIN,
    ST_PIX_HI,
    ST_PIX_LO,
    ST_DONE
  } sched_state_t;

endpackage

// File: rtl/lcd_window_cmd_rom.sv
// Window command table for the ST7789.
// Maps a byte index 0..10 to the {dc, byte} pair that re-arms the panel
// write window: CASET xs xe, RASET ys ye, RAMWR. Start/end addresses come
// from the panel RAM offsets and the visible resolution.
// Ports:
//   index    in   4  byte position within the command sequence
//   dc       out  1  0 = command opcode, 1 = argument byte
//   cmd_byte out  8  byte value
module lcd_window_cmd_rom
  import lcd_pkg::*;
#(
  parameter int unsigned H_RES   = 240,
  parameter int unsigned V_RES   = 135,
  parameter int unsigned COL_OFS = 40,
  parameter int unsigned ROW_OFS = 53
) (
  input  logic [3:0] index,
  output logic       dc,
  output logic [7:0] cmd_byte
);

  localparam logic [15:0] COL_START = 16'(COL_OFS);
  localparam logic [15:0] COL_END   = 16'(COL_OFS + H_RES - 1);
  localparam logic [15:0] ROW_START = 16'(ROW_OFS);
  localparam logic [15:0] ROW_END   = 16'(ROW_OFS + V_RES - 1);

  always_comb begin
    dc       = 1'b1;
    cmd_byte = '0;
    case (index)
      4'd0:  begin dc = 1'b0; cmd_byte = CASET; end
      4'd1:  cmd_byte = COL_START[15:8];
      4'd2:  cmd_byte = COL_START[7:0];
      4'd3:  cmd_byte = COL_END[15:8];
      4'd4:  cmd_byte = COL_END[7:0];
      4'd5:  begin dc = 1'b0; cmd_byte = RASET; end
      4'd6:  cmd_byte = ROW_START[15:8];
      4'd7:  cmd_byte = ROW_START[7:0];
      4'd8:  cmd_byte = ROW_END[15:8];
      4'd9:  cmd_byte = ROW_END[7:0];
      4'd10: begin dc = 1'b0; cmd_byte = RAMWR; end
      default: begin
        dc       = 1'b1;
        cmd_byte = '0;
      end
    endcase
  end

endmodule

// File: rtl/lcd_frame_scheduler.sv
// LCD frame scheduler.
// Once the panel is initialised, starts a frame every FRAME_CYCLES clocks:
// re-sends the ST7789 window commands, then streams H_RES*V_RES RGB565
// pixels (high byte first) fetched from a combinational pixel source, and
// pulses frame_tick when the last byte has been accepted. If a frame takes
// longer than its period the next frame starts immediately and the sticky
// overrun flag is raised.
// Ports:
//   clk, resetn     clock and synchronous active-low reset
//   init_done       panel init finished (level); idles while low
//   pix_x, pix_y    coordinates of the pixel requested from the source
//   pix_data        RGB565 value for (pix_x, pix_y), same cycle
//   byte_valid/byte_data/byte_dc/byte_ready
//                   valid/ready byte port to the SPI serializer
//   frame_tick      one-cycle pulse per completed frame
//   overrun         sticky: a frame period expired while still drawing
module lcd_frame_scheduler
  import lcd_pkg::*;
#(
  parameter int unsigned H_RES        = 240,
  parameter int unsigned V_RES        = 135,
  parameter int unsigned COL_OFS      = 40,
  parameter int unsigned ROW_OFS      = 53,
  parameter int unsigned FRAME_CYCLES = 900000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        init_done,
  output logic [8:0]  pix_x,
  output logic [7:0]  pix_y,
  input  logic [15:0] pix_data,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_dc,
  input  logic        byte_ready,
  output logic        frame_tick,
  output logic        overrun
);

  localparam int unsigned  TW       = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST  = TW'(FRAME_CYCLES - 1);
  localparam logic [8:0]   X_LAST   = 9'(H_RES - 1);
  localparam logic [7:0]   Y_LAST   = 8'(V_RES - 1);
  localparam logic [3:0]   IDX_LAST = 4'(CMD_BYTES - 1);

  sched_state_t  state;
  logic [TW-1:0] timer;
  logic          period_hit;
  logic          stop_req;
  logic [3:0]    cmd_idx;
  logic [7:0]    lo_latch;

  logic          rom_dc;
  logic [7:0]    rom_byte;

  logic          accept;
  logic          wrap;
  logic          halt;
  logic          start_frame;

  lcd_window_cmd_rom #(
    .H_RES   (H_RES),
    .V_RES   (V_RES),
    .COL_OFS (COL_OFS),
    .ROW_OFS (ROW_OFS)
  ) u_cmd_rom (
    .index    (cmd_idx),
    .dc       (rom_dc),
    .cmd_byte (rom_byte)
  );

  always_comb begin
    accept = byte_valid && byte_ready;
    wrap   = (timer == T_LAST);
    // init_done dropped at some point during this frame, or is low now
    halt   = stop_req || !init_done;
  end

  // A period boundary that lands exactly on this cycle counts as on time:
  // the next frame begins on the wrap edge, so consecutive frames are
  // exactly FRAME_CYCLES apart instead of FRAME_CYCLES+1.
  always_comb begin
    start_frame = 1'b0;
    case (state)
      ST_IDLE:          start_frame = init_done;
      ST_WAIT, ST_DONE: start_frame = !halt && (period_hit || wrap);
      default:          start_frame = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      timer      <= '0;
      period_hit <= 1'b0;
      stop_req   <= 1'b0;
      cmd_idx    <= '0;
      lo_latch   <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_dc    <= 1'b0;
      frame_tick <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_tick <= 1'b0;

      // Frame period timer: held at zero while idle, restarted at every
      // frame start, otherwise free-running with a wrap flag.
      if (state == ST_IDLE || start_frame) begin
        timer      <= '0;
        period_hit <= 1'b0;
      end else begin
        timer <= wrap ? '0 : timer + 1'b1;
        if (wrap) begin
          period_hit <= 1'b1;
        end
      end

      // Remember an init_done drop so the frame in flight completes and
      // the scheduler then parks in IDLE.
      if (state == ST_IDLE) begin
        stop_req <= 1'b0;
      end else if (!init_done) begin
        stop_req <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start_frame) begin
            state <= ST_WIN;
          end
        end

        ST_WAIT: begin
          if (halt) begin
            state <= ST_IDLE;
          end else if (start_frame) begin
            state <= ST_WIN;
          end
        end

        ST_WIN: begin
          if (!byte_valid) begin
            byte_valid <= 1'b1;
            byte_data  <= rom_byte;
            byte_dc    <= rom_dc;
          end else if (accept) begin
            byte_valid <= 1'b0;
            if (cmd_idx == IDX_LAST) begin
              cmd_idx <= '0;
              state   <= ST_PIX_HI;
            end else begin
              cmd_idx <= cmd_idx + 1'b1;
            end
          end
        end

        ST_PIX_HI: begin
          if (!byte_valid) begin
            byte_valid <= 1'b1;
            byte_data  <= pix_data[15:8];
            byte_dc    <= 1'b1;
            lo_latch   <= pix_data[7:0];
          end else if (accept) begin
            byte_valid <= 1'b0;
            state      <= ST_PIX_LO;
          end
        end

        ST_PIX_LO: begin
          if (!byte_valid) begin
            byte_valid <= 1'b1;
            byte_data  <= lo_latch;
            byte_dc    <= 1'b1;
          end else if (accept) begin
            byte_valid <= 1'b0;
            if (pix_x == X_LAST) begin
              pix_x <= '0;
              if (pix_y == Y_LAST) begin
                // coordinates return to the origin as DONE is entered
                pix_y      <= '0;
                frame_tick <= 1'b1;
                state      <= ST_DONE;
              end else begin
                pix_y <= pix_y + 1'b1;
                state <= ST_PIX_HI;
              end
            end else begin
              pix_x <= pix_x + 1'b1;
              state <= ST_PIX_HI;
            end
          end
        end

        ST_DONE: begin
          if (halt) begin
            state <= ST_IDLE;
          end else if (start_frame) begin
            if (period_hit) begin
              overrun <= 1'b1;
            end
            state <= ST_WIN;
          end else begin
            state <= ST_WAIT;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
module tb_lcd_frame_scheduler;

  localparam int unsigned H   = 4;
  localparam int unsigned V   = 2;
  localparam int unsigned CO  = 40;
  localparam int unsigned RO  = 53;
  localparam int unsigned F   = 200;
  localparam int unsigned FB  = 20;
  localparam int unsigned NB  = 11 + 2 * H * V;

  localparam logic [7:0] CMD_LIT [11] = '{8'h2A, 8'h00, 8'h28, 8'h00, 8'h2B,
                                          8'h2B, 8'h00, 8'h35, 8'h00, 8'h36,
                                          8'h2C};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance A: nominal period
  logic        resetn, init_done, byte_ready;
  logic [8:0]  pix_x;
  logic [7:0]  pix_y;
  logic [15:0] pix_data;
  logic        byte_valid, byte_dc, frame_tick, overrun;
  logic [7:0]  byte_data;

  // instance B: short period to force overrun
  logic        resetn_b, init_done_b, byte_ready_b;
  logic [8:0]  pix_x_b;
  logic [7:0]  pix_y_b;
  logic [15:0] pix_data_b;
  logic        byte_valid_b, byte_dc_b, frame_tick_b, overrun_b;
  logic [7:0]  byte_data_b;

  always_comb pix_data   = {pix_x[7:0], pix_y};
  always_comb pix_data_b = {pix_x_b[7:0], pix_y_b};

  lcd_frame_scheduler #(
    .H_RES(H), .V_RES(V), .COL_OFS(CO), .ROW_OFS(RO), .FRAME_CYCLES(F)
  ) dut (
    .clk(clk), .resetn(resetn), .init_done(init_done),
    .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
    .byte_ready(byte_ready), .frame_tick(frame_tick), .overrun(overrun)
  );

  lcd_frame_scheduler #(
    .H_RES(H), .V_RES(V), .COL_OFS(CO), .ROW_OFS(RO), .FRAME_CYCLES(FB)
  ) dut_b (
    .clk(clk), .resetn(resetn_b), .init_done(init_done_b),
    .pix_x(pix_x_b), .pix_y(pix_y_b), .pix_data(pix_data_b),
    .byte_valid(byte_valid_b), .byte_data(byte_data_b), .byte_dc(byte_dc_b),
    .byte_ready(byte_ready_b), .frame_tick(frame_tick_b), .overrun(overrun_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Expected {dc, byte} for position k of a frame's byte stream.
  function automatic logic [8:0] exp_byte(input int unsigned k);
    int unsigned p;
    if (k < 11) return {(k != 0 && k != 5 && k != 10), CMD_LIT[k]};
    p = (k - 11) / 2;
    if (((k - 11) % 2) == 0) return {1'b1, 8'(p % H)};
    return {1'b1, 8'(p / H)};
  endfunction

  typedef struct {
    int unsigned stall;  // ready-low cycles before accepting
    logic        dc;
    logic [7:0]  data;
  } vec_t;

  vec_t tbl [2*NB];

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic run_vecs(input int unsigned first, input int unsigned n);
    logic [7:0]  hd;
    logic        hdc;
    logic        stable;
    logic        tick_bad;
    int unsigned w;
    tick_bad = 1'b0;
    for (int unsigned i = first; i < first + n; i++) begin
      byte_ready = (tbl[i].stall == 0);
      w = 0;
      while (!byte_valid && w < 1000) begin
        @(negedge clk);
        if (frame_tick) tick_bad = 1'b1;
        w++;
      end
      if (!byte_valid) begin
        check("byte_wait_timeout", byte_valid, 1);
        return;
      end
      hd = byte_data;
      hdc = byte_dc;
      stable = 1'b1;
      for (int unsigned s = 0; s < tbl[i].stall; s++) begin
        @(negedge clk);
        if (!byte_valid || byte_data != hd || byte_dc != hdc) stable = 1'b0;
      end
      if (tbl[i].stall != 0) check($sformatf("hold_stable_%0d", i), stable, 1);
      check($sformatf("vec%0d_data", i), hd, tbl[i].data);
      check($sformatf("vec%0d_dc", i), hdc, tbl[i].dc);
      byte_ready = 1'b1;
      @(negedge clk);
      if (i == first + n - 1) begin
        check("frame_tick_pulse", frame_tick, 1);
        @(negedge clk);
        check("frame_tick_single", frame_tick, 0);
      end else if (frame_tick) begin
        tick_bad = 1'b1;
      end
    end
    check("no_early_tick", tick_bad, 0);
  endtask

  task automatic reset_a();
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Reference model: byte stream content plus frame pacing.
  // Frame n+1 presents its first byte at max(first_n + F, tick_n + 2);
  // overrun becomes due when the tick-based term is the later one.
  logic        mon_en = 1'b0;
  int unsigned bidx;
  logic        prev_valid, prev_acc, pdc, have_prev, exp_ovr;
  logic [7:0]  pd;
  longint      prev_p0, tick_c, exp_tick_at, exp_p;
  int          frames_seen;

  always begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      if (prev_valid && !prev_acc)
        check("stall_hold", {byte_valid, byte_dc, byte_data}, {1'b1, pdc, pd});
      if (byte_valid && !prev_valid && bidx == 0) begin
        if (have_prev) begin
          exp_p = (prev_p0 + F > tick_c + 2) ? prev_p0 + F : tick_c + 2;
          check("win_start_cycle", cyc, exp_p);
          check("overrun_flag", overrun, exp_ovr);
        end
        prev_p0 = cyc;
        have_prev = 1'b1;
      end
      if (frame_tick || cyc == exp_tick_at) begin
        check("frame_tick_time", frame_tick, (cyc == exp_tick_at));
        if (frame_tick) begin
          tick_c = cyc;
          frames_seen++;
          if (tick_c + 2 > prev_p0 + F) exp_ovr = 1'b1;
        end
      end
      if (byte_valid && byte_ready) begin
        check("stream_byte", {byte_dc, byte_data}, exp_byte(bidx));
        bidx = (bidx == NB - 1) ? 0 : bidx + 1;
        if (bidx == 0) exp_tick_at = cyc + 1;
      end
      prev_valid = byte_valid;
      prev_acc   = byte_valid && byte_ready;
      pd         = byte_data;
      pdc        = byte_dc;
    end
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic        bad;
    int unsigned w;
    int unsigned den;

    for (int unsigned k = 0; k < NB; k++) begin
      tbl[k].stall = 0;
      {tbl[k].dc, tbl[k].data} = exp_byte(k);
      tbl[NB + k] = tbl[k];
      tbl[NB + k].stall = 7;
    end

    resetn = 1'b0; init_done = 1'b0; byte_ready = 1'b1;
    resetn_b = 1'b0; init_done_b = 1'b0; byte_ready_b = 1'b1;
    repeat (3) @(negedge clk);

    check("reset_outputs",
          {pix_x, pix_y, byte_valid, byte_data, byte_dc, frame_tick, overrun}, 0);
    resetn = 1'b1;

    // idle while init_done low
    bad = 1'b0;
    repeat (500) begin
      @(negedge clk);
      if (byte_valid || frame_tick) bad = 1'b1;
    end
    check("idle_quiet", bad, 0);

    // window + stream, then same frame content under back-pressure
    init_done = 1'b1;
    run_vecs(0, NB);
    run_vecs(NB, NB);

    // pacing with ready=1, then randomized ready against the model
    byte_ready = 1'b1;
    init_done = 1'b0;
    reset_a();
    bidx = 0; prev_valid = 1'b0; prev_acc = 1'b0; have_prev = 1'b0;
    exp_ovr = 1'b0; exp_tick_at = -1; tick_c = 0; prev_p0 = 0; frames_seen = 0;
    mon_en = 1'b1;
    init_done = 1'b1;
    w = 0;
    while (frames_seen < 4 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("pacing_frames", frames_seen, 4);
    check("pacing_no_overrun", overrun, 0);

    den = 1;
    for (int unsigned c = 0; c < 3000; c++) begin
      if (c % 150 == 0) begin
        case ($urandom_range(2, 0))
          0:       den = 1;
          1:       den = 3;
          default: den = 14;
        endcase
      end
      @(negedge clk);
      byte_ready = (den == 1) ? 1'b1 : ($urandom_range(den - 1, 0) == 0);
    end
    mon_en = 1'b0;
    check("random_progress", (frames_seen >= 6), 1);

    // reset in the middle of pixel (2,1)
    byte_ready = 1'b1;
    reset_a();
    w = 0;
    while (!(pix_x == 9'd2 && pix_y == 8'd1) && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("reach_pixel_2_1", {pix_x, pix_y}, {9'd2, 8'd1});
    resetn = 1'b0;
    @(negedge clk);
    check("midframe_reset",
          {pix_x, pix_y, byte_valid, byte_data, byte_dc, frame_tick, overrun}, 0);
    resetn = 1'b1;
    run_vecs(0, NB);

    // overrun on the short-period instance
    resetn_b = 1'b1;
    init_done_b = 1'b1;
    w = 0;
    while (!frame_tick_b && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("ovr_first_tick", frame_tick_b, 1);
    check("ovr_clear_during_tick", overrun_b, 0);
    check("ovr_coords_origin", {pix_x_b, pix_y_b}, 0);
    @(negedge clk);
    check("ovr_set_after_frame", overrun_b, 1);
    check("ovr_bubble", byte_valid_b, 0);
    @(negedge clk);
    check("ovr_next_win", {byte_valid_b, byte_dc_b, byte_data_b}, {1'b1, 1'b0, 8'h2A});
    w = 0;
    while (!frame_tick_b && w < 300) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    check("ovr_sticky", overrun_b, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
